player_data_tx: RTL

PLAYER_DATA_TX -- requirements
Module: player_data_tx

---
 rtl/player_data_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/player_data_tx.sv
// Frames the local player state into a 6-byte UART packet (sync, payload, checksum).
// It sends one packet per send_tick and queues at most one more request.
module player_data_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_tick,
    input  logic [1:0]  game_active,
    input  logic [11:0] char_x,
    input  logic [3:0]  class_aggro,
    input  logic [6:0]  boss_hp,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        pkt_sent,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, HOLD, DONE} state_t;

    state_t      r_state;
    logic        r_pending;
    logic [3:0]  r_seq;
    logic [11:0] r_x;
    logic [3:0]  r_aggro;
    logic [6:0]  r_hp;
    logic [1:0]  r_ga;
    logic [3:0]  r_pseq;
    logic [7:0]  r_chk;
    logic [2:0]  r_idx;

    logic [7:0]  w_in_b1, w_in_b2, w_in_b3, w_in_b4;
    logic [7:0]  w_byte;

    // The checksum is formed from the live inputs in the same cycle they are captured.
    assign w_in_b1 = char_x[7:0];
    assign w_in_b2 = {class_aggro, char_x[11:8]};
    assign w_in_b3 = {1'b0, boss_hp};
    assign w_in_b4 = {r_seq, 2'b00, game_active};

    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_x[7:0];
            3'd2:    w_byte = {r_aggro, r_x[11:8]};
            3'd3:    w_byte = {1'b0, r_hp};
            3'd4:    w_byte = {r_pseq, 2'b00, r_ga};
            3'd5:    w_byte = r_chk;
            default: w_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_seq     <= 4'd0;
            r_x       <= 12'd0;
            r_aggro   <= 4'd0;
            r_hp      <= 7'd0;
            r_ga      <= 2'd0;
            r_pseq    <= 4'd0;
            r_chk     <= 8'd0;
            r_idx     <= 3'd0;
            tx_data   <= 8'd0;
            tx_wr     <= 1'b0;
            pkt_sent  <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tx_wr    <= 1'b0;
            pkt_sent <= 1'b0;
            overrun  <= 1'b0;

            // Any request outside IDLE (DONE included) is queued once, then dropped.
            if (r_state != IDLE && send_tick) begin
                if (r_pending) overrun   <= 1'b1;
                else           r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (send_tick || r_pending) begin
                        r_pending <= 1'b0;
                        if (game_active != 2'd0) begin
                            r_state <= LOAD;
                            busy    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_x     <= char_x;
                    r_aggro <= class_aggro;
                    r_hp    <= boss_hp;
                    r_ga    <= game_active;
                    r_pseq  <= r_seq;
                    r_chk   <= w_in_b1 ^ w_in_b2 ^ w_in_b3 ^ w_in_b4;
                    r_idx   <= 3'd0;
                    r_state <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data <= w_byte;
                        tx_wr   <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_idx == 3'd5) begin
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= SEND;
                    end
                end
                DONE: begin
                    pkt_sent <= 1'b1;
                    r_seq    <= r_seq + 4'd1;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
